// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and bus-side signals of the IF/MEM memory port arbiter.
// The arbiter takes the master view; the pipeline plus the memory take the slave view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SELW = DW / 8;

  logic [5:0]      stall;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            stallreq_if;
  logic            mem_req;
  logic            mem_we;
  logic [SELW-1:0] mem_sel;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            stallreq_mem;
  logic            bus_req;
  logic            bus_we;
  logic [SELW-1:0] bus_sel;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW-1:0]   bus_rdata;
  logic            bus_ack;
  logic            bus_err;

  modport master (
    input  stall, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    output if_rdata, stallreq_if, mem_rdata, stallreq_mem,
           bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
  );

  modport slave (
    output stall, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    input  if_rdata, stallreq_if, mem_rdata, stallreq_mem,
           bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and load/store,
// MEM first, one transaction at a time, holding results until the pipeline takes them.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master io_arb
);
  localparam int SELW = DW / 8;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE_MEM,
    ST_SERVE_IF
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_grant_mem;
  logic            w_grant_if;
  logic            w_timeout;
  logic            w_finish;
  logic            w_finish_if;
  logic            w_finish_mem;

  logic            r_bus_req;
  logic            r_bus_we;
  logic [SELW-1:0] r_bus_sel;
  logic [AW-1:0]   r_bus_addr;
  logic [DW-1:0]   r_bus_wdata;
  logic            r_bus_err;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_mem_rdata;
  logic            r_if_done;
  logic            r_mem_done;
  logic [CW-1:0]   r_cnt;

  // Only the IF/ID and MEM/WB hold bits matter to this block.
  logic w_unused_stall;
  assign w_unused_stall = ^{io_arb.stall[5], io_arb.stall[3:2], io_arb.stall[0]};

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_timeout   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_arb.mem_req && !r_mem_done) begin
          w_grant_mem = 1'b1;
          w_state_nxt = ST_SERVE_MEM;
        end else if (io_arb.if_req && !r_if_done) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_SERVE_IF;
        end
      end
      ST_SERVE_MEM, ST_SERVE_IF: begin
        w_timeout = (TIMEOUT > 0) && !io_arb.bus_ack && (r_cnt == CNT_LAST);
        w_finish  = io_arb.bus_ack || w_timeout;
        if (w_finish) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_finish_if  = w_finish && (r_state == ST_SERVE_IF);
  assign w_finish_mem = w_finish && (r_state == ST_SERVE_MEM);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_err   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_bus_err <= w_timeout;

      if (w_grant_mem) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= io_arb.mem_we;
        r_bus_sel   <= io_arb.mem_sel;
        r_bus_addr  <= io_arb.mem_addr;
        r_bus_wdata <= io_arb.mem_wdata;
        r_cnt       <= '0;
      end else if (w_grant_if) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= 1'b0;
        r_bus_sel   <= '1;
        r_bus_addr  <= io_arb.if_addr;
        r_bus_wdata <= '0;
        r_cnt       <= '0;
      end else begin
        if (w_finish) r_bus_req <= 1'b0;
        if (r_state != ST_IDLE && !io_arb.bus_ack) r_cnt <= r_cnt + CW'(1);
      end

      // Aborted transactions and stores return zero data.
      if (w_finish_if)
        r_if_rdata <= io_arb.bus_ack ? io_arb.bus_rdata : '0;
      if (w_finish_mem)
        r_mem_rdata <= (io_arb.bus_ack && !r_bus_we) ? io_arb.bus_rdata : '0;

      // A result is kept only if the requester is still asking for it.
      if (w_finish_if && io_arb.if_req)  r_if_done <= 1'b1;
      else if (!io_arb.stall[1])         r_if_done <= 1'b0;

      if (w_finish_mem && io_arb.mem_req) r_mem_done <= 1'b1;
      else if (!io_arb.stall[4])          r_mem_done <= 1'b0;
    end
  end

  assign io_arb.bus_req      = r_bus_req;
  assign io_arb.bus_we       = r_bus_we;
  assign io_arb.bus_sel      = r_bus_sel;
  assign io_arb.bus_addr     = r_bus_addr;
  assign io_arb.bus_wdata    = r_bus_wdata;
  assign io_arb.bus_err      = r_bus_err;
  assign io_arb.if_rdata     = r_if_rdata;
  assign io_arb.mem_rdata    = r_mem_rdata;
  assign io_arb.stallreq_if  = io_arb.if_req  & ~r_if_done;
  assign io_arb.stallreq_mem = io_arb.mem_req & ~r_mem_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboarded bus transactions and results,
// plus directed checks on latency, priority, stall hold, timeout, reset and stores.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) u_if ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_arb (u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_txn_t;

  bus_txn_t    exp_bus_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_mem_q[$];

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2402_0005 : {a[15:0], ~a[15:0]};
  endfunction

  int ack_delay = 0;
  bit ack_en    = 1'b1;
  int resp_cnt  = 0;

  // Memory responder: acks ack_delay cycles after bus_req is first seen.
  initial begin
    u_if.bus_ack   = 1'b0;
    u_if.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (ack_en) begin
        u_if.bus_ack   = 1'b0;
        u_if.bus_rdata = 32'hBAD0_BAD0;
        if (u_if.bus_req) begin
          if (resp_cnt >= ack_delay) begin
            u_if.bus_ack   = 1'b1;
            u_if.bus_rdata = mem_model(u_if.bus_addr);
            resp_cnt       = 0;
          end else begin
            resp_cnt++;
          end
        end else begin
          resp_cnt = 0;
        end
      end
    end
  end

  // Scoreboard monitor: bus transactions on rise, stability while held, results on release.
  logic     prev_req  = 1'b0;
  logic     prev_sif  = 1'b0;
  logic     prev_smem = 1'b0;
  bus_txn_t cur_txn;
  bus_txn_t exp_txn;
  initial begin
    forever begin
      @(negedge clk);
      if (u_if.bus_req && !prev_req) begin
        cur_txn = {u_if.bus_we, u_if.bus_sel, u_if.bus_addr, u_if.bus_wdata};
        if (exp_bus_q.size() == 0) begin
          check("bus_q_empty_on_req", 32'(exp_bus_q.size()), 32'd1);
        end else begin
          exp_txn = exp_bus_q.pop_front();
          check("bus_addr", u_if.bus_addr, exp_txn.addr);
          check("bus_we", 32'(u_if.bus_we), 32'(exp_txn.we));
          check("bus_sel", 32'(u_if.bus_sel), 32'(exp_txn.sel));
          if (exp_txn.we) check("bus_wdata", u_if.bus_wdata, exp_txn.wdata);
        end
      end else if (u_if.bus_req) begin
        check("bus_stable",
              32'({u_if.bus_we, u_if.bus_sel, u_if.bus_addr, u_if.bus_wdata} == cur_txn), 32'd1);
      end
      if (u_if.if_req && !u_if.stallreq_if && prev_sif) begin
        if (exp_if_q.size() == 0) check("if_q_empty_on_result", 32'(exp_if_q.size()), 32'd1);
        else check("if_rdata", u_if.if_rdata, exp_if_q.pop_front());
      end
      if (u_if.mem_req && !u_if.stallreq_mem && prev_smem) begin
        if (exp_mem_q.size() == 0) check("mem_q_empty_on_result", 32'(exp_mem_q.size()), 32'd1);
        else check("mem_rdata", u_if.mem_rdata, exp_mem_q.pop_front());
      end
      prev_req  = u_if.bus_req;
      prev_sif  = u_if.stallreq_if;
      prev_smem = u_if.stallreq_mem;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_if(input logic [31:0] a, input bit push_res);
    u_if.if_req  = 1'b1;
    u_if.if_addr = a;
    exp_bus_q.push_back({1'b0, 4'hF, a, 32'h0});
    if (push_res) exp_if_q.push_back(mem_model(a));
  endtask

  task automatic start_mem(input logic we, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] wd, input bit push_res, input logic [31:0] res);
    u_if.mem_req   = 1'b1;
    u_if.mem_we    = we;
    u_if.mem_sel   = sel;
    u_if.mem_addr  = a;
    u_if.mem_wdata = wd;
    exp_bus_q.push_back({we, sel, a, wd});
    if (push_res) exp_mem_q.push_back(res);
  endtask

  task automatic wait_if_done();
    int n = 0;
    do begin
      tick();
      n++;
    end while (u_if.stallreq_if && n < 60);
    if (u_if.stallreq_if) check("if_wait_bound", 32'(u_if.stallreq_if), 32'd0);
    u_if.if_req = 1'b0;
  endtask

  task automatic wait_mem_done();
    int n = 0;
    do begin
      tick();
      n++;
    end while (u_if.stallreq_mem && n < 60);
    if (u_if.stallreq_mem) check("mem_wait_bound", 32'(u_if.stallreq_mem), 32'd0);
    u_if.mem_req = 1'b0;
    u_if.mem_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int mem_cyc;
    int if_cyc;
    logic [31:0] held;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  sel;

    rst            = 1'b1;
    u_if.stall     = '0;
    u_if.if_req    = 1'b0;
    u_if.if_addr   = '0;
    u_if.mem_req   = 1'b0;
    u_if.mem_we    = 1'b0;
    u_if.mem_sel   = '0;
    u_if.mem_addr  = '0;
    u_if.mem_wdata = '0;
    repeat (3) tick();
    check("rst_bus_req", 32'(u_if.bus_req), 32'd0);
    check("rst_bus_err", 32'(u_if.bus_err), 32'd0);
    check("rst_bus_addr", u_if.bus_addr, 32'd0);
    check("rst_bus_sel", 32'(u_if.bus_sel), 32'd0);
    check("rst_if_rdata", u_if.if_rdata, 32'd0);
    check("rst_mem_rdata", u_if.mem_rdata, 32'd0);
    check("rst_stallreq_if", 32'(u_if.stallreq_if), 32'd0);
    rst = 1'b0;
    tick();

    // Fetch with ack two cycles after bus_req is first seen.
    ack_delay = 2;
    start_if(32'h40, 1'b1);
    #1 check("t1_stallreq_if_on_req", 32'(u_if.stallreq_if), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 3) begin
        check($sformatf("t1_bus_req_c%0d", c), 32'(u_if.bus_req), 32'd1);
      end else begin
        check("t1_bus_req_c4", 32'(u_if.bus_req), 32'd0);
        check("t1_stallreq_if_c4", 32'(u_if.stallreq_if), 32'd0);
        check("t1_if_rdata_c4", u_if.if_rdata, 32'h2402_0005);
      end
    end
    u_if.if_req = 1'b0;
    tick();
    check("t1_no_refetch", 32'(u_if.bus_req), 32'd0);

    // Simultaneous load and fetch: MEM first, one idle cycle, then IF.
    ack_delay = 1;
    start_mem(1'b0, 4'hF, 32'h100, 32'h0, 1'b1, mem_model(32'h100));
    start_if(32'h40, 1'b1);
    mem_cyc = 0;
    if_cyc  = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (u_if.mem_req && !u_if.stallreq_mem) begin
        mem_cyc = c;
        u_if.mem_req = 1'b0;
      end
      if (u_if.if_req && !u_if.stallreq_if) begin
        if_cyc = c;
        u_if.if_req = 1'b0;
        break;
      end
    end
    check("t2_mem_done_cycle", 32'(mem_cyc), 32'd3);
    check("t2_if_done_cycle", 32'(if_cyc), 32'd6);
    tick();

    // Fetch completes while IF/ID is held for four cycles.
    ack_delay  = 0;
    u_if.stall = 6'b000010;
    start_if(32'h80, 1'b1);
    tick();
    check("t3_bus_req_c1", 32'(u_if.bus_req), 32'd1);
    tick();
    check("t3_stallreq_if_c2", 32'(u_if.stallreq_if), 32'd0);
    held = u_if.if_rdata;
    for (int c = 3; c <= 5; c++) begin
      tick();
      check($sformatf("t3_if_rdata_hold_c%0d", c), u_if.if_rdata, mem_model(32'h80));
      check($sformatf("t3_stallreq_if_c%0d", c), 32'(u_if.stallreq_if), 32'd0);
      check($sformatf("t3_no_bus_req_c%0d", c), 32'(u_if.bus_req), 32'd0);
    end
    u_if.stall = '0;
    tick();
    check("t3_done_cleared", 32'(u_if.stallreq_if), 32'd1);
    check("t3_rdata_kept", u_if.if_rdata, held);
    u_if.if_req = 1'b0;
    tick();
    check("t3_no_bus_req_after", 32'(u_if.bus_req), 32'd0);

    // Store: bus fields stay put even when the requester changes mid-flight.
    ack_delay = 3;
    start_mem(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF, 1'b1, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("t6_bus_req_c%0d", c), 32'(u_if.bus_req), 32'd1);
      check($sformatf("t6_bus_we_c%0d", c), 32'(u_if.bus_we), 32'd1);
      check($sformatf("t6_bus_sel_c%0d", c), 32'(u_if.bus_sel), 32'h3);
      check($sformatf("t6_bus_wdata_c%0d", c), u_if.bus_wdata, 32'hDEAD_BEEF);
      if (c == 2) begin
        u_if.mem_wdata = 32'h0;
        u_if.mem_addr  = 32'h999;
        u_if.mem_sel   = 4'hF;
      end
    end
    tick();
    check("t6_bus_req_after_ack", 32'(u_if.bus_req), 32'd0);
    check("t6_stallreq_mem", 32'(u_if.stallreq_mem), 32'd0);
    check("t6_mem_rdata_store", u_if.mem_rdata, 32'h0);
    u_if.mem_req = 1'b0;
    u_if.mem_we  = 1'b0;
    tick();

    // Load dropped before ack: data latched, done flag not set.
    ack_delay = 3;
    start_mem(1'b0, 4'hF, 32'h180, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    u_if.mem_req = 1'b0;
    tick();
    tick();
    tick();
    check("discard_bus_req", 32'(u_if.bus_req), 32'd0);
    check("discard_rdata", u_if.mem_rdata, mem_model(32'h180));
    u_if.mem_req = 1'b1;
    #1 check("discard_no_done", 32'(u_if.stallreq_mem), 32'd1);
    u_if.mem_req = 1'b0;
    tick();

    // Load with no ack: abort after eight cycles of bus_req.
    ack_en = 1'b0;
    start_mem(1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c <= 8) begin
        check($sformatf("t4_bus_req_c%0d", c), 32'(u_if.bus_req), 32'd1);
        check($sformatf("t4_bus_err_c%0d", c), 32'(u_if.bus_err), 32'd0);
      end else begin
        check("t4_bus_err_pulse", 32'(u_if.bus_err), 32'd1);
        check("t4_bus_req_dropped", 32'(u_if.bus_req), 32'd0);
        check("t4_stallreq_mem", 32'(u_if.stallreq_mem), 32'd0);
        check("t4_mem_rdata_zero", u_if.mem_rdata, 32'h0);
      end
    end
    u_if.mem_req = 1'b0;
    tick();
    check("t4_bus_err_one_cycle", 32'(u_if.bus_err), 32'd0);

    // Reset in the second serve cycle; an ack right after is ignored.
    start_if(32'h44, 1'b0);
    tick();
    tick();
    check("t5_bus_req_before_rst", 32'(u_if.bus_req), 32'd1);
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    u_if.bus_ack   = 1'b1;
    u_if.bus_rdata = 32'h1234_5678;
    check("t5_bus_req", 32'(u_if.bus_req), 32'd0);
    check("t5_if_rdata", u_if.if_rdata, 32'h0);
    check("t5_mem_rdata", u_if.mem_rdata, 32'h0);
    check("t5_bus_addr", u_if.bus_addr, 32'h0);
    check("t5_stallreq_follows_req_hi", 32'(u_if.stallreq_if), 32'd1);
    u_if.if_req = 1'b0;
    #1 check("t5_stallreq_follows_req_lo", 32'(u_if.stallreq_if), 32'd0);
    tick();
    u_if.bus_ack = 1'b0;
    check("t5_ack_ignored_req", 32'(u_if.bus_req), 32'd0);
    check("t5_ack_ignored_rdata", u_if.if_rdata, 32'h0);
    ack_en = 1'b1;
    tick();

    // Mixed random traffic checked by the scoreboard.
    for (int k = 0; k < 12; k++) begin
      ack_delay = int'($urandom_range(0, 4));
      a   = 32'($urandom_range(1, 4095)) << 2;
      wd  = $urandom;
      sel = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 2))
        0: begin
          start_if(a, 1'b1);
          wait_if_done();
        end
        1: begin
          start_mem(1'b0, 4'hF, a, wd, 1'b1, mem_model(a));
          wait_mem_done();
        end
        default: begin
          start_mem(1'b1, sel, a, wd, 1'b1, 32'h0);
          wait_mem_done();
        end
      endcase
      tick();
    end

    repeat (3) tick();
    check("bus_q_drained", 32'(exp_bus_q.size()), 32'd0);
    check("if_q_drained", 32'(exp_if_q.size()), 32'd0);
    check("mem_q_drained", 32'(exp_mem_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
